// File: rtl/dim_pkg.sv
// Shared encodings for the dimming zone controller: modes, frame FSM states, error bit positions.
package dim_pkg;

    localparam logic [1:0] MODE_MAX = 2'd1;
    localparam logic [1:0] MODE_AVE = 2'd2;
    localparam logic [1:0] MODE_COR = 2'd3;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        COMMIT
    } state_e;

    localparam int unsigned ERR_IDX = 0;
    localparam int unsigned ERR_OVR = 1;

endpackage

// File: rtl/btn_debounce.sv
// Active-low button debouncer: 2-flop synchroniser, then a stable-low counter that
// emits a single accept pulse once the button has been low for DEB_CYC cycles.
module btn_debounce #(
    parameter int unsigned DEB_CYC = 500000
) (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_btn_n,
    output logic O_accept
);

    localparam int unsigned CW = $clog2(DEB_CYC + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], I_btn_n};
            if (sync_q[1]) begin
                cnt_q <= '0;
            end else if (cnt_q != CW'(DEB_CYC)) begin
                // Saturates at DEB_CYC so a held button accepts only once.
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign O_accept = !sync_q[1] && (cnt_q == CW'(DEB_CYC - 1));

endmodule

// File: rtl/dimming_zone_ctrl.sv
// Per-zone backlight level controller with per-frame atomic publish.
// Define DIM_IIR_EN to enable the per-zone temporal IIR filter.
module dimming_zone_ctrl
    import dim_pkg::*;
#(
    parameter int unsigned ZONES    = 360,
    parameter int unsigned DW       = 8,
    parameter int unsigned IW       = 9,
    parameter int unsigned DEB_CYC  = 500000,
    parameter int unsigned ALPHA_SH = 2
) (
    input  logic                I_clk,
    input  logic                I_rst_n,
    input  logic                I_max_n,
    input  logic                I_ave_n,
    input  logic                I_cor_n,
    input  logic                I_zone_valid,
    input  logic [IW-1:0]       I_zone_idx,
    input  logic [DW-1:0]       I_zone_max,
    input  logic [DW-1:0]       I_zone_avg,
    input  logic                I_frame_done,
    output logic                O_zone_ready,
    output logic [1:0]          O_gray_mode,
    output logic [ZONES*DW-1:0] O_led_light,
    output logic                O_update,
    output logic [1:0]          O_err
);

    logic acc_max, acc_ave, acc_cor;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_max (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_btn_n(I_max_n), .O_accept(acc_max)
    );
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_ave (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_btn_n(I_ave_n), .O_accept(acc_ave)
    );
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_cor (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_btn_n(I_cor_n), .O_accept(acc_cor)
    );

    logic [1:0] mode_q;
    logic [1:0] frame_mode_q;
    state_e     state_q;
    logic       drain_cnt_q;
    logic       ready_q;
    logic       update_q;
    logic [1:0] err_q;
    logic [ZONES*DW-1:0] led_q;

    logic [DW-1:0] work_q [ZONES];
    logic          s1_vld_q;
    logic [IW-1:0] s1_idx_q;
    logic [DW-1:0] s1_tgt_q;
    logic [DW-1:0] tgt;
    logic [DW-1:0] new_level;
    logic          accept;
    logic          in_range;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            mode_q <= MODE_MAX;
        end else if (acc_max) begin
            mode_q <= MODE_MAX;
        end else if (acc_ave) begin
            mode_q <= MODE_AVE;
        end else if (acc_cor) begin
            mode_q <= MODE_COR;
        end
    end

    assign accept   = I_zone_valid && ready_q;
    assign in_range = 32'(I_zone_idx) < ZONES;

    always_comb begin
        tgt = I_zone_max;
        case (frame_mode_q)
            MODE_AVE: tgt = I_zone_avg;
            MODE_COR: tgt = DW'(({1'b0, I_zone_max} + {1'b0, I_zone_avg} + (DW+1)'(1)) >> 1);
            default:  tgt = I_zone_max;
        endcase
    end

    // S1: capture index and target; out-of-range samples never enter the pipe.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            s1_tgt_q <= '0;
        end else begin
            s1_vld_q <= accept && in_range;
            s1_idx_q <= I_zone_idx;
            s1_tgt_q <= tgt;
        end
    end

`ifdef DIM_IIR_EN
    logic                 bypass_q;
    logic [DW-1:0]        old_level;
    logic signed [DW+1:0] diff, step, sum;

    // Read-modify-write happens in one cycle, so a back-to-back sample to the same
    // zone always sees the previous sample's committed result.
    always_comb begin
        old_level = work_q[s1_idx_q];
        diff      = $signed({2'b00, s1_tgt_q}) - $signed({2'b00, old_level});
        step      = diff >>> ALPHA_SH;
        if (diff != '0 && step == '0) begin
            step = diff[DW+1] ? {(DW+2){1'b1}} : (DW+2)'(1);
        end
        sum = $signed({2'b00, old_level}) + step;
        if (bypass_q)     new_level = s1_tgt_q;
        else if (sum[DW+1]) new_level = '0;
        else if (sum[DW])   new_level = '1;
        else                new_level = sum[DW-1:0];
    end
`else
    assign new_level = s1_tgt_q;
`endif

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int i = 0; i < ZONES; i++) work_q[i] <= '0;
        end else if (s1_vld_q) begin
            work_q[s1_idx_q] <= new_level;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q      <= ACCUM;
            drain_cnt_q  <= 1'b0;
            ready_q      <= 1'b0;
            update_q     <= 1'b0;
            led_q        <= '0;
            frame_mode_q <= MODE_MAX;
            err_q        <= '0;
`ifdef DIM_IIR_EN
            bypass_q     <= 1'b0;
`endif
        end else begin
            update_q <= 1'b0;
            if (accept && !in_range) err_q[ERR_IDX] <= 1'b1;
            if (I_frame_done && state_q != ACCUM) err_q[ERR_OVR] <= 1'b1;
            case (state_q)
                ACCUM: begin
                    ready_q <= !I_frame_done;
                    if (I_frame_done) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    ready_q <= 1'b0;
                    if (drain_cnt_q) state_q <= COMMIT;
                    drain_cnt_q <= 1'b1;
                end
                default: begin
                    for (int i = 0; i < ZONES; i++) led_q[i*DW +: DW] <= work_q[i];
                    update_q     <= 1'b1;
                    frame_mode_q <= mode_q;
`ifdef DIM_IIR_EN
                    bypass_q     <= (mode_q != frame_mode_q);
`endif
                    ready_q      <= 1'b1;
                    state_q      <= ACCUM;
                end
            endcase
        end
    end

    assign O_zone_ready = ready_q;
    assign O_gray_mode  = mode_q;
    assign O_led_light  = led_q;
    assign O_update     = update_q;
    assign O_err        = err_q;

endmodule

// File: tb/tb_dimming_zone_ctrl.sv
// Self-checking bench for dimming_zone_ctrl: frame-level behavioural model plus literal pins.
module tb_dimming_zone_ctrl;

    localparam int ZONES = 360;
    localparam int DW    = 8;
    localparam int IW    = 9;
    localparam int DEB   = 16;
    localparam int ASH   = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                max_n, ave_n, cor_n;
    logic                zvalid;
    logic [IW-1:0]       zidx;
    logic [DW-1:0]       zmax, zavg;
    logic                fdone;
    logic                zready;
    logic [1:0]          gmode;
    logic [ZONES*DW-1:0] led;
    logic                upd;
    logic [1:0]          err;

    dimming_zone_ctrl #(
        .ZONES(ZONES), .DW(DW), .IW(IW), .DEB_CYC(DEB), .ALPHA_SH(ASH)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_max_n(max_n), .I_ave_n(ave_n), .I_cor_n(cor_n),
        .I_zone_valid(zvalid), .I_zone_idx(zidx), .I_zone_max(zmax), .I_zone_avg(zavg),
        .I_frame_done(fdone), .O_zone_ready(zready), .O_gray_mode(gmode),
        .O_led_light(led), .O_update(upd), .O_err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Frame-level model: working levels, published levels, mode state, errors.
    int         m_work [ZONES];
    int         m_pub  [ZONES];
    int         m_mode, m_fmode;
    bit         m_bypass;
    logic [1:0] m_err;
    bit         exp_upd, mode_known, chk_en;

    function automatic int target(int m, int mx, int av);
        if (m == 1) return mx;
        if (m == 2) return av;
        return (mx + av + 1) / 2;
    endfunction

    function automatic int filt(int old, int t);
        int d, s, r;
        d = t - old;
        s = d >>> ASH;
        if (d != 0 && s == 0) s = (d > 0) ? 1 : -1;
        r = old + s;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    function automatic int zone_of(int i);
        return int'(led[i*DW +: DW]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ZONES; i++) begin
            m_work[i] = 0;
            m_pub[i]  = 0;
        end
        m_mode = 1; m_fmode = 1; m_bypass = 0; m_err = 2'b00; exp_upd = 0; mode_known = 1;
    endtask

    task automatic model_sample(input int idx, input int mx, input int av);
        int t;
        if (idx >= ZONES) begin
            m_err[0] = 1'b1;
        end else begin
            t = target(m_fmode, mx, av);
`ifdef DIM_IIR_EN
            m_work[idx] = m_bypass ? t : filt(m_work[idx], t);
`else
            m_work[idx] = t;
`endif
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [ZONES*DW-1:0] exp_bus;
            int bad;
            bad = -1;
            for (int i = 0; i < ZONES; i++) exp_bus[i*DW +: DW] = DW'(m_pub[i]);
            n_cmp++;
            if (led !== exp_bus) begin
                n_fail++;
                for (int i = ZONES - 1; i >= 0; i--)
                    if (led[i*DW +: DW] !== exp_bus[i*DW +: DW]) bad = i;
                $display("FAIL led_light: zone %0d got %0d expected %0d at %0t", bad,
                         led[bad*DW +: DW], exp_bus[bad*DW +: DW], $time);
            end
            check("update", 32'(upd), 32'(exp_upd));
            check("err", 32'(err), 32'(m_err));
            if (mode_known) check("gray_mode", 32'(gmode), 32'(m_mode));
        end
    end

    task automatic send(input int idx, input int mx, input int av);
        @(negedge clk);
        fdone = 1'b0; zvalid = 1'b1; zidx = IW'(idx); zmax = DW'(mx); zavg = DW'(av);
        @(posedge clk); #1;
        model_sample(idx, mx, av);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            zvalid = 1'b0; fdone = 1'b0;
        end
    endtask

    // Frame end: fixed 2-cycle drain, 1-cycle commit, publish visible 3 edges after frame_done.
    task automatic frame(input bit with_s, input int idx, input int mx, input int av,
                         input bit overrun);
        @(negedge clk);
        fdone = 1'b1; zvalid = with_s; zidx = IW'(idx); zmax = DW'(mx); zavg = DW'(av);
        @(posedge clk); #1;
        if (with_s) model_sample(idx, mx, av);
        @(negedge clk);
        fdone = overrun; zvalid = 1'b0;
        check("ready_in_drain", 32'(zready), 32'd0);
        @(posedge clk); #1;
        if (overrun) m_err[1] = 1'b1;
        @(negedge clk);
        fdone = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < ZONES; i++) m_pub[i] = m_work[i];
        exp_upd  = 1;
        m_bypass = (m_mode != m_fmode);
        m_fmode  = m_mode;
        @(posedge clk); #1;
        exp_upd = 0;
    endtask

    task automatic press(input bit bmax, input bit bave, input bit bcor, input int cyc,
                         input int new_mode);
        mode_known = 0;
        @(negedge clk);
        zvalid = 1'b0; fdone = 1'b0;
        max_n = !bmax; ave_n = !bave; cor_n = !bcor;
        repeat (cyc) @(negedge clk);
        max_n = 1'b1; ave_n = 1'b1; cor_n = 1'b1;
        repeat (4) @(negedge clk);
        m_mode = new_mode;
        mode_known = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        chk_en = 0;
        rst_n = 1'b0; max_n = 1'b1; ave_n = 1'b1; cor_n = 1'b1;
        zvalid = 1'b0; zidx = '0; zmax = '0; zavg = '0; fdone = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_mode", 32'(gmode), 32'd1);
        check("rst_led_any", 32'(|led), 32'd0);
        check("rst_update", 32'(upd), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(zready), 32'd0);
        rst_n = 1'b1;
        #1 check("ready_before_edge", 32'(zready), 32'd0);
        @(posedge clk); #1;
        check("ready_rise", 32'(zready), 32'd1);
        chk_en = 1;

`ifdef DIM_IIR_EN
        begin
            int lit [3] = '{25, 43, 57};
            for (int f = 0; f < 30; f++) begin
                send(0, 100, 30);
                frame(0, 0, 0, 0, 0);
                if (f < 3) check("iir_step", 32'(zone_of(0)), 32'(lit[f]));
            end
            check("iir_converged", 32'(zone_of(0)), 32'd100);
        end
`else
        send(0, 100, 30);
        frame(0, 0, 0, 0, 0);
        check("mode1_zone0", 32'(zone_of(0)), 32'd100);
`endif

        press(0, 1, 0, 16, 2);
        check("ave_accepted", 32'(gmode), 32'd2);
        press(0, 1, 0, 15, 2);
        press(1, 0, 0, 15, 2);
        check("short_press_ignored", 32'(gmode), 32'd2);
        press(1, 0, 1, 16, 1);
        check("max_over_cor", 32'(gmode), 32'd1);
        press(0, 0, 1, 16, 3);
        check("cor_accepted", 32'(gmode), 32'd3);

        frame(0, 0, 0, 0, 0);
        send(5, 200, 101);
        frame(0, 0, 0, 0, 0);
        check("cor_zone5", 32'(zone_of(5)), 32'd151);
        check("cor_zone4", 32'(zone_of(4)), 32'd0);

        send(7, 80, 80);
        send(7, 40, 40);
        frame(1, 9, 60, 20, 0);
`ifndef DIM_IIR_EN
        check("fwd_zone7", 32'(zone_of(7)), 32'd40);
        check("same_cycle_zone9", 32'(zone_of(9)), 32'd40);
`endif

        send(400, 10, 10);
        send(12, 30, 50);
        idle(2);
        check("err_idx", 32'(err), 32'd1);
        frame(0, 0, 0, 0, 1);
        check("err_overrun", 32'(err), 32'd3);
        idle(3);

        send(11, 90, 90);
        idle(1);
        chk_en = 0;
        rst_n = 1'b0;
        #1;
        check("midreset_led", 32'(|led), 32'd0);
        check("midreset_err", 32'(err), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1;
        frame(0, 0, 0, 0, 0);
        check("midreset_zone11", 32'(zone_of(11)), 32'd0);
        idle(3);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
